// File: rtl/hazard_unit_pkg.sv
// Shared opcode definitions for the decoder, pipeline and hazard unit, plus
// helpers that classify an opcode by which sources it reads and whether it
// redirects control flow.
package hazard_unit_pkg;

  typedef enum logic [5:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    JAL, JALR, LUI, AUIPC, NOP
  } opcode_out_t;

  // Reads rs1: R-type, I-type ALU, loads, stores, branches and JALR.
  function automatic logic uses_rs1(opcode_out_t op);
    logic r;
    case (op)
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      LB, LH, LW, LBU, LHU,
      SB, SH, SW,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      JALR:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Reads rs2: R-type, stores and branches.
  function automatic logic uses_rs2(opcode_out_t op);
    logic r;
    case (op)
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      SB, SH, SW,
      BEQ, BNE, BLT, BGE, BLTU, BGEU: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Branches and jumps make the sequentially fetched instruction wrong-path.
  function automatic logic is_ctrl(opcode_out_t op);
    logic r;
    case (op)
      BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR: r = 1'b1;
      default:                                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of hazard-unit signals: ID/EX observation inputs, pipeline control
// outputs and the performance counters.
import hazard_unit_pkg::*;

interface hazard_if #(
  parameter int CNT_W = 32
) ();
  opcode_out_t        opcode_in;
  logic [4:0]         id_reg1_idx;
  logic [4:0]         id_reg2_idx;
  logic [4:0]         ex_reg_wr_idx;
  logic               ex_do_mem_read_en;
  logic               hazard_fe_enable;
  logic               hazard_if_id_clear;
  logic               hazard_id_ex_clear;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   flush_count;

  // Pipeline side: supplies stage state, consumes the controls.
  modport master (
    output opcode_in, id_reg1_idx, id_reg2_idx, ex_reg_wr_idx, ex_do_mem_read_en,
    input  hazard_fe_enable, hazard_if_id_clear, hazard_id_ex_clear,
    input  stall_count, flush_count
  );

  // Hazard unit side.
  modport slave (
    input  opcode_in, id_reg1_idx, id_reg2_idx, ex_reg_wr_idx, ex_do_mem_read_en,
    output hazard_fe_enable, hazard_if_id_clear, hazard_id_ex_clear,
    output stall_count, flush_count
  );
endinterface

// File: rtl/hazard_event_counter.sv
// Free-running event counter with increment enable; wraps modulo 2^CNT_W.
module hazard_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: advance by one on an event, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Load-use and control hazard detector next to the ID stage. Pipeline
// controls are purely combinational; only the debug counters are clocked.
import hazard_unit_pkg::*;

module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hif
);

  logic load_use;
  logic ctrl;
  logic stall_evt;
  logic flush_evt;

  // Hazard detection and prioritised control outputs. A load-use stall wins
  // over a control flush: the branch itself must wait for its operand, so
  // it stays in ID and is re-evaluated next cycle.
  always_comb begin
    load_use = hif.ex_do_mem_read_en
             & (hif.ex_reg_wr_idx != 5'd0)
             & ((uses_rs1(hif.opcode_in) & (hif.id_reg1_idx == hif.ex_reg_wr_idx))
              | (uses_rs2(hif.opcode_in) & (hif.id_reg2_idx == hif.ex_reg_wr_idx)));
    ctrl     = is_ctrl(hif.opcode_in);

    hif.hazard_fe_enable   = 1'b1;
    hif.hazard_if_id_clear = 1'b0;
    hif.hazard_id_ex_clear = 1'b0;
    if (load_use) begin
      hif.hazard_fe_enable   = 1'b0;
      hif.hazard_id_ex_clear = 1'b1;
    end else if (ctrl) begin
      hif.hazard_fe_enable   = 1'b0;
      hif.hazard_if_id_clear = 1'b1;
    end

    stall_evt = load_use;
    flush_evt = ctrl & ~load_use;
  end

  hazard_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (stall_evt),
    .count_o  (hif.stall_count)
  );

  hazard_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (flush_evt),
    .count_o  (hif.flush_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed vector table, reset and bubble
// sequences, then random stimulus against a set-based reference model.
import hazard_unit_pkg::*;

module tb_hazard_unit;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CW)) hif ();

  hazard_unit #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stall_m = 0;
  int flush_m = 0;

  typedef struct {
    opcode_out_t op;
    logic [4:0]  r1, r2, rd;
    logic        mr;
    logic [2:0]  exp; // {fe_enable, if_id_clear, id_ex_clear}
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: operand usage expressed as sets of operations.
  function automatic logic [2:0] model(opcode_out_t op, logic [4:0] r1, logic [4:0] r2,
                                       logic [4:0] rd, logic mr);
    bit reads1, reads2, ctl, lu;
    reads1 = op inside {[ADD:AND], [ADDI:SRAI], [LB:LHU], [SB:SW], [BEQ:BGEU], JALR};
    reads2 = op inside {[ADD:AND], [SB:SW], [BEQ:BGEU]};
    ctl    = op inside {[BEQ:BGEU], JAL, JALR};
    lu     = mr && rd != 0 && ((reads1 && r1 == rd) || (reads2 && r2 == rd));
    if (lu)  return 3'b001;
    if (ctl) return 3'b010;
    return 3'b100;
  endfunction

  task automatic drive(input opcode_out_t op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic mr);
    hif.opcode_in         = op;
    hif.id_reg1_idx       = r1;
    hif.id_reg2_idx       = r2;
    hif.ex_reg_wr_idx     = rd;
    hif.ex_do_mem_read_en = mr;
  endtask

  function automatic logic [2:0] outs();
    return {hif.hazard_fe_enable, hif.hazard_if_id_clear, hif.hazard_id_ex_clear};
  endfunction

  // One pipeline cycle: drive, check combinational outputs, clock, check counters.
  task automatic step(input opcode_out_t op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic mr, input logic [2:0] exp,
                      input string name);
    drive(op, r1, r2, rd, mr);
    #1;
    check({name, "_outs"}, {29'd0, outs()}, {29'd0, exp});
    stall_m += exp[0];
    flush_m += exp[1];
    @(posedge clk);
    #1;
    check({name, "_stall"}, {24'd0, hif.stall_count}, stall_m % 256);
    check({name, "_flush"}, {24'd0, hif.flush_count}, flush_m % 256);
  endtask

  vec_t vecs [$];

  initial begin
    opcode_out_t rop;
    logic [4:0] a, b, c;
    logic m;

    vecs.push_back('{ADD,   5'd1, 5'd2, 5'd3, 1'b0, 3'b100, "no_hazard"});
    vecs.push_back('{ADD,   5'd5, 5'd2, 5'd5, 1'b1, 3'b001, "load_use_rs1"});
    vecs.push_back('{BEQ,   5'd1, 5'd2, 5'd3, 1'b0, 3'b010, "control"});
    vecs.push_back('{BEQ,   5'd7, 5'd2, 5'd7, 1'b1, 3'b001, "priority"});
    vecs.push_back('{ADD,   5'd0, 5'd0, 5'd0, 1'b1, 3'b100, "load_x0"});
    vecs.push_back('{LUI,   5'd5, 5'd5, 5'd5, 1'b1, 3'b100, "lui_no_src"});
    vecs.push_back('{SW,    5'd1, 5'd9, 5'd9, 1'b1, 3'b001, "store_rs2"});
    vecs.push_back('{ADDI,  5'd1, 5'd9, 5'd9, 1'b1, 3'b100, "itype_no_rs2"});
    vecs.push_back('{JAL,   5'd4, 5'd4, 5'd4, 1'b1, 3'b010, "jal_no_src"});
    vecs.push_back('{JALR,  5'd4, 5'd1, 5'd4, 1'b1, 3'b001, "jalr_rs1"});
    vecs.push_back('{BGEU,  5'd1, 5'd6, 5'd6, 1'b1, 3'b001, "branch_rs2"});
    vecs.push_back('{AUIPC, 5'd3, 5'd3, 5'd3, 1'b1, 3'b100, "auipc"});
    vecs.push_back('{NOP,   5'd3, 5'd3, 5'd3, 1'b1, 3'b100, "nop"});
    vecs.push_back('{LW,    5'd8, 5'd0, 5'd8, 1'b1, 3'b001, "load_after_load"});
    vecs.push_back('{JALR,  5'd2, 5'd0, 5'd3, 1'b1, 3'b010, "jalr_no_match"});

    // Reset state: counters clear asynchronously, outputs unaffected.
    drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("reset_stall", {24'd0, hif.stall_count}, 32'd0);
    check("reset_flush", {24'd0, hif.flush_count}, 32'd0);
    check("reset_outs",  {29'd0, outs()}, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      step(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].rd, vecs[i].mr, vecs[i].exp, vecs[i].name);

    // Load-use then the same instruction against the inserted bubble.
    step(SUB, 5'd10, 5'd11, 5'd11, 1'b1, 3'b001, "bubble_first");
    step(SUB, 5'd10, 5'd11, 5'd11, 1'b0, 3'b100, "bubble_second");

    // Mid-cycle reset with nonzero counters.
    drive(BNE, 5'd1, 5'd2, 5'd3, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_stall", {24'd0, hif.stall_count}, 32'd0);
    check("midrst_flush", {24'd0, hif.flush_count}, 32'd0);
    check("midrst_outs_ctrl", {29'd0, outs()}, 32'd2);
    drive(OR, 5'd12, 5'd0, 5'd12, 1'b1);
    #1;
    check("midrst_outs_lu", {29'd0, outs()}, 32'd1);
    @(posedge clk);
    #1;
    check("rst_hold_stall", {24'd0, hif.stall_count}, 32'd0);
    check("rst_hold_flush", {24'd0, hif.flush_count}, 32'd0);
    rst = 1'b0;
    stall_m = 0;
    flush_m = 0;
    step(OR, 5'd12, 5'd0, 5'd12, 1'b1, 3'b001, "after_rst");

    // Random phase; small register range to hit matches, counters wrap.
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 19) == 0) rop = opcode_out_t'(6'h3F);
      else                            rop = opcode_out_t'($urandom_range(0, 37));
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      c = 5'($urandom_range(0, 3));
      m = 1'($urandom_range(0, 1));
      step(rop, a, b, c, m, model(rop, a, b, c, m), $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Combinational hazard detector for the 5-stage RISC-V pipeline, placed alongside the ID stage. It detects load-use data hazards between the instruction in ID and a load in EX, and control hazards from a branch or jump in ID. It drives the fetch enable and the IF/ID and ID/EX flush controls. A small clocked block keeps stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, default 32: width of the event counters.

Ports:
- clk  input  1  pipeline clock; only the counters use it.
- rst  input  1  asynchronous, active-high reset; affects only the counters.
- opcode_in  input  opcode_out_t  decoded operation of the instruction in ID.
- id_reg1_idx  input  5  rs1 index of the ID instruction.
- id_reg2_idx  input  5  rs2 index of the ID instruction.
- ex_reg_wr_idx  input  5  rd index of the instruction in EX.
- ex_do_mem_read_en  input  1  instruction in EX is a load.
- hazard_fe_enable  output  1  1 = PC/fetch may advance; 0 = hold.
- hazard_if_id_clear  output  1  flush the IF/ID register (insert bubble).
- hazard_id_ex_clear  output  1  flush the ID/EX register (insert bubble).
- stall_count  output  CNT_W  number of cycles with a load-use stall.
- flush_count  output  CNT_W  number of cycles with a control flush.

## Operation
- uses_rs1: true for R-type, I-type ALU, loads, stores, branches and JALR. False for LUI, AUIPC and JAL.
- uses_rs2: true for R-type, stores and branches. False otherwise.
- is_ctrl: true when opcode_in is BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL or JALR.
- load_use = ex_do_mem_read_en & (ex_reg_wr_idx != 0) & ((uses_rs1 & id_reg1_idx == ex_reg_wr_idx) | (uses_rs2 & id_reg2_idx == ex_reg_wr_idx)).
- Output priority:
  - If load_use: fe_enable=0, id_ex_clear=1, if_id_clear=0. The ID instruction is held and re-evaluated next cycle. This holds even when is_ctrl is true.
  - Else if is_ctrl: fe_enable=0, if_id_clear=1, id_ex_clear=0. The branch proceeds to EX and the wrong-path fetch is squashed.
  - Else: fe_enable=1, if_id_clear=0, id_ex_clear=0.
- A load to x0 never stalls.
- Unknown or NOP opcodes use no sources and are not control. They behave as the no-hazard case unless load_use applies.

## Timing
- The three hazard outputs are purely combinational with zero cycle latency. They are independent of clk and rst and valid within the same cycle as the inputs.
- Counters update on the clk rising edge:
  - stall_count increments when load_use is true.
  - flush_count increments when is_ctrl is true and load_use is false.
- On rst (asynchronous, active-high) both counters go to 0 immediately and hold there while rst is high. The hazard outputs are unaffected by reset.
- Counters wrap modulo 2^CNT_W.
- A load-use followed by the same ID instruction in the next cycle does not stall again, because ID/EX then holds a bubble with ex_do_mem_read_en=0.

## Structure
- opcode_out_t (enum: ADD, SUB, ..., LW, SW, BEQ..BGEU, JAL, JALR, LUI, AUIPC, NOP) belongs in the shared opcodes package, used by the decoder and the pipeline.
- The package also provides the helper functions uses_rs1, uses_rs2 and is_ctrl.
- One natural sub-module: hazard_event_counter. It is a CNT_W-bit counter with asynchronous reset and an increment enable, instantiated twice.

## Test plan
- No hazard: ADD, rs1=1, rs2=2, ex rd=3, mem_read=0 -> fe_enable=1, if_id_clear=0, id_ex_clear=0.
- Load-use: ADD, rs1=5, rs2=2, ex rd=5, mem_read=1 -> id_ex_clear=1, fe_enable=0, if_id_clear=0. After 1 clock, stall_count=1.
- Control: BEQ, mem_read=0 -> if_id_clear=1, fe_enable=0, id_ex_clear=0. After 1 clock, flush_count=1.
- Priority: BEQ, rs1=7, ex rd=7, mem_read=1 -> id_ex_clear=1, if_id_clear=0, fe_enable=0. flush_count unchanged.
- Boundaries:
  - ADD, rs2=0, ex rd=0, mem_read=1 -> no stall.
  - LUI with id_reg1_idx=5, ex rd=5, mem_read=1 -> no stall.
- Reset: assert rst mid-count with the counters at nonzero values -> both counters read 0 immediately while hazard outputs keep tracking their inputs.
